mul_dispatch: RTL

Operand-dispatch and result-capture stage that sits directly in front of and behind the shift-add multiplier datapath and its controller. It buffers incoming operand pairs in a small FIFO and issues one pair at a time with a single-cycle `mul_start` pulse. It then tracks the multiplier's `ready` handshake to detect completion and holds the product in an output register with a valid/ready handshake toward the consumer.

---
 rtl/mul_dispatch.sv | 112 +++++++++++
 1 files changed

// File: rtl/mul_dispatch.sv
// Operand dispatch and result capture around a shift-add multiplier.
// Buffers operand pairs, issues them one at a time, and holds each product until the consumer takes it.
module mul_dispatch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_ready,
  input  logic [2*WIDTH-1:0]       mul_product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       out_product,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_LOW  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]       state;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic             push;
  logic             pop;
  logic             out_free;
  logic             capture;

  assign in_ready  = (level < FULL_LEVEL) && !rst;
  assign push      = in_valid && in_ready;
  assign pop       = (state == ISSUE) && (level != '0);
  assign out_free  = !out_valid || out_ready;
  assign capture   = (state == WAIT_DONE) && mul_ready && out_free;
  assign mul_start = (state == ISSUE);
  assign busy      = (state != IDLE);

  // Storage needs no reset: level and the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Operands are latched at the IDLE->ISSUE load and held until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((level != '0) && mul_ready) begin
            mul_a <= mem_a[rd_ptr];
            mul_b <= mem_b[rd_ptr];
            state <= ISSUE;
          end
        end
        ISSUE:     state <= WAIT_LOW;
        WAIT_LOW:  if (!mul_ready) state <= WAIT_DONE;
        WAIT_DONE: if (capture) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // A capture wins over a same-cycle pop, so out_valid stays high with the new product.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_product <= '0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_product <= mul_product;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
